// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encodings, grant IDs and default watchdog limit
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RESP} arb_state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam int ARB_TIMEOUT = 255;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: saturating cycle counter that flags when the current cycle reaches limit
module bus_watchdog #(
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);
  logic [TO_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (reset || clr) r_cnt <= '0;
    else if (en && !(&r_cnt)) r_cnt <= r_cnt + TO_W'(1);
  // r_cnt counts completed cycles, so the current one is r_cnt+1
  assign expired = en && (({1'b0, r_cnt} + (TO_W+1)'(1)) >= {1'b0, limit});
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch (I) and load/store (D) with alternating grants
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);
  arb_state_t  r_state, w_next;
  logic        r_gnt, r_err, r_m_we;
  logic [3:0]  r_m_be;
  logic [31:0] r_m_addr, r_m_wdata, r_i_rdata, r_d_rdata;
  logic        w_busy, w_pick_d, w_expired;
  bus_watchdog #(.TO_W(TO_W)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (!w_busy),
    .en      (w_busy),
    .limit   (TO_W'(TIMEOUT)),
    .expired (w_expired)
  );
  always_comb begin
    w_busy   = r_state == ARB_BUSY_I || r_state == ARB_BUSY_D;
    w_pick_d = d_req && (!i_req || r_gnt == GNT_I);
    w_next   = r_state;
    case (r_state)
      ARB_IDLE:   if (i_req || d_req) w_next = w_pick_d ? ARB_BUSY_D : ARB_BUSY_I;
      ARB_BUSY_I,
      ARB_BUSY_D: if (m_ready || w_expired) w_next = ARB_RESP;
      default:    w_next = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) r_state <= ARB_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (reset) begin
      r_gnt     <= GNT_I;
      r_err     <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_be    <= '0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (r_state == ARB_IDLE && (i_req || d_req)) begin
        r_gnt     <= w_pick_d ? GNT_D : GNT_I;
        r_m_we    <= w_pick_d && d_we;
        r_m_be    <= w_pick_d ? d_be : 4'hF;
        r_m_addr  <= w_pick_d ? d_addr : i_addr;
        r_m_wdata <= w_pick_d ? d_wdata : '0;
      end
      if (w_busy && m_ready) begin
        if (r_gnt == GNT_I) r_i_rdata <= m_rdata;
        else if (!r_m_we) r_d_rdata <= m_rdata;
      end else if (w_busy && w_expired) begin
        if (r_gnt == GNT_I) r_i_rdata <= '0;
        else r_d_rdata <= '0;
        r_err <= 1'b1;
      end
      if (r_state == ARB_RESP) r_err <= 1'b0;
    end
  assign m_req   = w_busy;
  assign m_we    = r_m_we;
  assign m_be    = r_m_be;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_ack   = r_state == ARB_RESP && r_gnt == GNT_I;
  assign d_ack   = r_state == ARB_RESP && r_gnt == GNT_D;
  assign bus_err = r_state == ARB_RESP && r_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized accesses checked against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, reset;
  logic i_req, i_ack, d_req, d_we, d_ack, bus_err, m_req, m_we, m_ready;
  logic [3:0] d_be, m_be;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  int n_chk = 0, n_pass = 0;
  logic last_d;
  logic [31:0] ei, ed;
  always #5 clk = ~clk;
  mem_bus_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  // Entered in an IDLE cycle; a requester already holding req keeps its fields.
  // w = idle memory cycles before m_ready; w >= TO means memory never answers.
  task automatic access(input logic ir, input logic dr, input int w,
                        input logic [31:0] ia, input logic [31:0] da, input logic dwe,
                        input logic [3:0] dbe, input logic [31:0] dwd, input logic [31:0] rd);
    logic wd, to;
    logic [31:0] ea;
    int busy;
    if (!i_req) i_addr = ia;
    if (!d_req) begin
      d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dwd;
    end
    i_req = i_req | ir;
    d_req = d_req | dr;
    m_ready = 1'($urandom);
    m_rdata = $urandom;
    wd = d_req && (!i_req || !last_d);
    last_d = wd;
    ea = wd ? d_addr : i_addr;
    to = w >= TO;
    busy = to ? TO : w + 1;
    step();
    for (int n = 0; n < busy; n++) begin
      chk("busy_m_req", m_req, 1);
      chk("busy_m_addr", m_addr, ea);
      chk("busy_m_we", m_we, wd & d_we);
      chk("busy_m_be", m_be, wd ? d_be : 4'hF);
      if (wd) chk("busy_m_wdata", m_wdata, d_wdata);
      chk("busy_acks", {i_ack, d_ack}, 0);
      m_ready = n == w;
      m_rdata = n == w ? rd : $urandom;
      step();
    end
    if (to) begin
      if (wd) ed = 0; else ei = 0;
    end else if (!wd) ei = rd;
    else if (!d_we) ed = rd;
    chk("resp_m_req", m_req, 0);
    chk("resp_i_ack", i_ack, !wd);
    chk("resp_d_ack", d_ack, wd);
    chk("resp_bus_err", bus_err, to);
    chk("resp_i_rdata", i_rdata, ei);
    chk("resp_d_rdata", d_rdata, ed);
    if (wd) d_req = 0; else i_req = 0;
    m_ready = 1'($urandom);
    m_rdata = $urandom;
    step();
    chk("idle_m_req", m_req, 0);
    chk("idle_acks", {i_ack, d_ack, bus_err}, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end
  initial begin
    reset = 1; i_req = 0; d_req = 0; d_we = 0; d_be = 0; i_addr = 0; d_addr = 0;
    d_wdata = 0; m_rdata = 0; m_ready = 0;
    last_d = 0; ei = 0; ed = 0;
    step(); step();
    chk("rst_ctrl", {m_req, m_we, i_ack, d_ack, bus_err}, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    reset = 0;
    d_addr = 32'h40; d_we = 0; d_be = 4'hF; d_req = 1;
    step();
    chk("mid_m_req", m_req, 1);
    m_ready = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_d_ack", d_ack, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    last_d = 0;
    access(1, 1, 0, 32'h100, 0, 0, 0, 0, 32'hA5A5_0001);
    access(1, 0, 0, 32'h100, 0, 0, 0, 0, 32'hA5A5_0002);
    access(1, 0, 1, 32'h3000, 0, 0, 0, 0, 32'h2408_0001);
    for (int k = 0; k < 2; k++) begin
      access(1, 1, 0, 32'h200 + 4 * k, 32'h10, 0, 4'hF, 0, 32'hDEAD_BEEF);
      access(1, 1, 0, 32'h200, 32'h10, 0, 4'hF, 0, 32'h1111_0000 + k);
    end
    access(0, 1, 0, 0, 32'h10, 0, 4'hF, 0, 32'hDEAD_BEEF);
    access(0, 1, 0, 0, 32'h20, 1, 4'b0011, 32'h1234_ABCD, 32'h5555_5555);
    access(1, 0, TO + 3, 32'h500, 0, 0, 0, 0, 32'h7777_7777);
    access(1, 0, 0, 32'h504, 0, 0, 0, 0, 32'h8888_8888);
    access(0, 1, 7, 0, 32'h60, 0, 4'hF, 0, 32'h0BAD_F00D);
    for (int k = 0; k < 60; k++) begin
      logic ir, dr;
      ir = 1'($urandom);
      dr = 1'($urandom);
      if (!ir && !dr && !i_req && !d_req) begin
        m_ready = 1'($urandom);
        step();
        chk("rand_idle_m_req", m_req, 0);
      end else
        access(ir, dr, $urandom_range(0, TO + 1), $urandom & ~32'h3, $urandom,
               1'($urandom), 4'($urandom), $urandom, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
